ddr3_rd_control: RTL and testbench
==================================

Name: ddr3_rd_control

Overview:
Downstream stage of the DDR3 write controller. It pops one fill header from the fill-header FIFO and issues DDR3 read commands covering the whole fill, including the stored header word and checksum word. Returned read data goes into the readout FIFO that feeds the transmit/readout path. Read data cannot be back-pressured, so the block throttles command issue with an in-flight credit counter.

Parameters:
MAX_INFLIGHT, 16, maximum read commands outstanding (issued, not yet returned); range 1..31
FIFO_HEADROOM_WAIT, 1, 1 = also block issue while rd_fifo_prog_full is high; 0 = ignore prog_full

Ports:
clk  in  1  DDR3 user-interface clock
reset  in  1  synchronous, active-high
rd_enabled  in  1  readout enabled; low forces IDLE
fill_header_dat  in  128  FWFT head of fill-header FIFO
fill_header_empty  in  1  fill-header FIFO empty
fill_header_rd_en  out  1  pop fill-header FIFO
ddr3_rd_addr  out  26  read address = {addr_gen[22:0],3'b0}
rd_app_en  out  1  read command request
rd_app_rdy  in  1  command accepted when high with rd_app_en
app_rd_data  in  128  read data from memory
app_rd_data_valid  in  1  app_rd_data valid this cycle
rd_fifo_dat  out  128  data to readout FIFO (registered)
rd_fifo_wr_en  out  1  write readout FIFO (registered)
rd_fifo_prog_full  in  1  readout FIFO nearly full
ddr3_rd_done  out  1  high while in DONE
ddr3_rd_hdr_err  out  1  sticky: header tag invalid
ddr3_rd_unexp_data  out  1  sticky: valid data seen with no command outstanding

Behaviour:
- Reset values: all outputs 0; addr_gen, counters and inflight are 0; state IDLE. Sticky errors clear only on reset.
- rd_enabled low: state forced to IDLE next cycle. Counters and sticky flags are kept.
- Header fields: tag [127:126] must be 2'b01; start address [57:35] (23 bits); burst count [87:64] (24 bits).
- Total bursts N = burst_count + 2, held in 25 bits, so 24'hFFFFFF gives 25'h1000001 with no overflow.
- IDLE: go to CHK_HDR when fill_header_empty is 0.
- CHK_HDR, 1 cycle:
  - Tag 2'b01: pulse fill_header_rd_en for 1 cycle, load addr_gen = start address, issue_cnt = N, ret_cnt = N; go to READ.
  - Any other tag: set ddr3_rd_hdr_err, do not pop, go to HDR_ERR.
- HDR_ERR: stay until reset or rd_enabled low.
- READ:
  - rd_app_en = (issue_cnt != 0) && (inflight < MAX_INFLIGHT) && !(FIFO_HEADROOM_WAIT && rd_fifo_prog_full).
  - On accept (rd_app_en & rd_app_rdy): addr_gen +1 (wraps modulo 2^23, 23'h7FFFFF to 0), issue_cnt -1, inflight +1.
  - rd_app_en and ddr3_rd_addr are combinational from registered state. ddr3_rd_addr holds while rd_app_en is high and rd_app_rdy is low.
  - When issue_cnt reaches 0, go to DRAIN.
- DRAIN: no commands issued. Go to DONE when ret_cnt == 0.
- Data return, in any state:
  - Each app_rd_data_valid cycle writes rd_fifo_dat = app_rd_data with rd_fifo_wr_en = 1, one cycle later. It is never dropped.
  - If ret_cnt != 0: ret_cnt -1 and inflight -1.
  - If ret_cnt == 0: set ddr3_rd_unexp_data; inflight unchanged.
  - Accept and return in the same cycle leaves inflight unchanged.
- DONE: ddr3_rd_done = 1; go to IDLE on the next cycle (fill complete; the next header is taken from IDLE).
- Latency: first command 2 cycles after fill_header_empty falls, if rd_app_rdy is high. rd_fifo_wr_en follows app_rd_data_valid by exactly 1 cycle.
- Reset mid-fill: state returns to IDLE and counters clear. Late-returning data after reset is still forwarded and flags ddr3_rd_unexp_data.

Optional Feature:
DDR3_RD_HDR_CMP_EN
- Defined:
  - Latch the popped fill header in CHK_HDR.
  - The first returned word of each fill (ret_cnt == N) is compared with the latched header.
  - On mismatch, raise added output ddr3_rd_hdr_mismatch (1 bit, sticky until reset). Data is still forwarded.
- Undefined: no latch and no comparator; the ddr3_rd_hdr_mismatch port does not exist.

Test Plan:
- Header tag 01, start 23'h000010, burst 3 -> 5 commands at addresses 26'h80,88,90,98,A0; 5 rd_fifo writes; ddr3_rd_done pulses 1 cycle; fill_header_rd_en pulses once.
- Header tag 2'b10 -> ddr3_rd_hdr_err = 1, no rd_app_en, no pop; stays until reset.
- Start 23'h7FFFFE, burst 1 -> addresses 26'h3FFFFF0, 3FFFFF8, 0000000.
- rd_app_rdy held low 10 cycles then high, MAX_INFLIGHT = 2 with data delayed 20 cycles -> ddr3_rd_addr stable while stalled; never more than 2 outstanding; all words forwarded in order.
- rd_fifo_prog_full asserted mid-fill -> rd_app_en drops next cycle; in-flight returns still written; issue resumes on deassert.
- Spurious app_rd_data_valid in IDLE -> ddr3_rd_unexp_data = 1; word still written to rd_fifo.

Source files
------------

// File: rtl/ddr3_rd_control.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_rd_control
// Description : Pops one fill header from the fill-header FIFO and issues
//               DDR3 read commands covering the whole fill (header word,
//               payload bursts and checksum word). Returned read data is
//               forwarded, registered, to the readout FIFO. Command issue is
//               throttled by an in-flight credit counter because read data
//               cannot be back-pressured.
//               Optional feature macro: DDR3_RD_HDR_CMP_EN (latches the popped
//               header and compares it with the first returned word).
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_rd_control #(
  parameter int MAX_INFLIGHT       = 16,
  parameter int FIFO_HEADROOM_WAIT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_enabled,
  input  logic [127:0] fill_header_dat,
  input  logic         fill_header_empty,
  output logic         fill_header_rd_en,
  output logic [25:0]  ddr3_rd_addr,
  output logic         rd_app_en,
  input  logic         rd_app_rdy,
  input  logic [127:0] app_rd_data,
  input  logic         app_rd_data_valid,
  output logic [127:0] rd_fifo_dat,
  output logic         rd_fifo_wr_en,
  input  logic         rd_fifo_prog_full,
  output logic         ddr3_rd_done,
  output logic         ddr3_rd_hdr_err,
  output logic         ddr3_rd_unexp_data
`ifdef DDR3_RD_HDR_CMP_EN
  ,
  output logic         ddr3_rd_hdr_mismatch
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHK_HDR = 3'd1,
    S_READ    = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4,
    S_HDR_ERR = 3'd5
  } state_t;

  localparam logic [4:0] MAX_INFL    = 5'(MAX_INFLIGHT);
  localparam logic       HEADROOM_EN = (FIFO_HEADROOM_WAIT != 0);

  state_t      state;
  state_t      state_nxt;
  logic [22:0] addr_gen;
  logic [24:0] issue_cnt;
  logic [24:0] ret_cnt;
  logic [4:0]  inflight;

  logic        load_hdr;
  logic        set_hdr_err;
  logic        accept;
  logic        ret_hit;
  logic        tag_ok;
  logic [22:0] hdr_start;
  logic [24:0] hdr_total;
  logic        unused_hdr_bits;

  // Header field decode; total bursts include the header and checksum words
  assign tag_ok    = (fill_header_dat[127:126] == 2'b01);
  assign hdr_start = fill_header_dat[57:35];
  assign hdr_total = {1'b0, fill_header_dat[87:64]} + 25'd2;

  // Header bits that carry no meaning for the read side
  assign unused_hdr_bits = ^{fill_header_dat[125:88], fill_header_dat[63:58],
                             fill_header_dat[34:0]};

  assign accept       = rd_app_en & rd_app_rdy;
  assign ret_hit      = app_rd_data_valid & (ret_cnt != 25'd0);
  assign ddr3_rd_addr = {addr_gen, 3'b000};

  // Next-state and command/handshake outputs from registered state
  always_comb begin
    state_nxt         = state;
    fill_header_rd_en = 1'b0;
    rd_app_en         = 1'b0;
    ddr3_rd_done      = 1'b0;
    load_hdr          = 1'b0;
    set_hdr_err       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fill_header_empty) state_nxt = S_CHK_HDR;
      end
      S_CHK_HDR: begin
        // Actions are gated so a header is never popped while being disabled
        if (rd_enabled) begin
          if (tag_ok) begin
            fill_header_rd_en = 1'b1;
            load_hdr          = 1'b1;
            state_nxt         = S_READ;
          end else begin
            set_hdr_err = 1'b1;
            state_nxt   = S_HDR_ERR;
          end
        end
      end
      S_READ: begin
        rd_app_en = (issue_cnt != 25'd0) && (inflight < MAX_INFL) &&
                    !(HEADROOM_EN && rd_fifo_prog_full);
        if ((issue_cnt == 25'd0) ||
            (rd_app_en && rd_app_rdy && (issue_cnt == 25'd1)))
          state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (ret_cnt == 25'd0) state_nxt = S_DONE;
      end
      S_DONE: begin
        ddr3_rd_done = 1'b1;
        state_nxt    = S_IDLE;
      end
      S_HDR_ERR: begin
        state_nxt = S_HDR_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!rd_enabled) state_nxt = S_IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Address generator, issue/return counters and in-flight credit tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_gen  <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      inflight  <= '0;
    end else begin
      if (load_hdr) begin
        addr_gen  <= hdr_start;
        issue_cnt <= hdr_total;
      end else if (accept) begin
        addr_gen  <= addr_gen + 23'd1;
        issue_cnt <= issue_cnt - 25'd1;
      end

      if (load_hdr)     ret_cnt <= hdr_total;
      else if (ret_hit) ret_cnt <= ret_cnt - 25'd1;

      case ({accept, ret_hit})
        2'b10:   inflight <= inflight + 5'd1;
        2'b01:   inflight <= inflight - 5'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Forward every returned word one cycle later; flag returns with nothing expected
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_fifo_dat        <= '0;
      rd_fifo_wr_en      <= 1'b0;
      ddr3_rd_hdr_err    <= 1'b0;
      ddr3_rd_unexp_data <= 1'b0;
    end else begin
      rd_fifo_wr_en <= app_rd_data_valid;
      if (app_rd_data_valid) rd_fifo_dat <= app_rd_data;
      if (set_hdr_err) ddr3_rd_hdr_err <= 1'b1;
      if (app_rd_data_valid && (ret_cnt == 25'd0)) ddr3_rd_unexp_data <= 1'b1;
    end
  end

`ifdef DDR3_RD_HDR_CMP_EN
  logic [127:0] hdr_latch;
  logic [24:0]  total_latch;

  // Keep the popped header and compare it with the first word of the fill
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_latch            <= '0;
      total_latch          <= '0;
      ddr3_rd_hdr_mismatch <= 1'b0;
    end else begin
      if (load_hdr) begin
        hdr_latch   <= fill_header_dat;
        total_latch <= hdr_total;
      end
      if (ret_hit && (ret_cnt == total_latch) && (app_rd_data != hdr_latch))
        ddr3_rd_hdr_mismatch <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr3_rd_control.sv
`timescale 1ns/1ps
module tb_ddr3_rd_control;

  localparam int MAXI = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rd_enabled = 1'b0;
  logic [127:0] fill_header_dat = '0;
  logic         fill_header_empty = 1'b1;
  logic         fill_header_rd_en;
  logic [25:0]  ddr3_rd_addr;
  logic         rd_app_en;
  logic         rd_app_rdy = 1'b1;
  logic [127:0] app_rd_data = '0;
  logic         app_rd_data_valid = 1'b0;
  logic [127:0] rd_fifo_dat;
  logic         rd_fifo_wr_en;
  logic         rd_fifo_prog_full = 1'b0;
  logic         ddr3_rd_done;
  logic         ddr3_rd_hdr_err;
  logic         ddr3_rd_unexp_data;
`ifdef DDR3_RD_HDR_CMP_EN
  logic         ddr3_rd_hdr_mismatch;
`endif

  ddr3_rd_control #(.MAX_INFLIGHT(MAXI), .FIFO_HEADROOM_WAIT(1)) dut (
    .clk                (clk),
    .reset              (reset),
    .rd_enabled         (rd_enabled),
    .fill_header_dat    (fill_header_dat),
    .fill_header_empty  (fill_header_empty),
    .fill_header_rd_en  (fill_header_rd_en),
    .ddr3_rd_addr       (ddr3_rd_addr),
    .rd_app_en          (rd_app_en),
    .rd_app_rdy         (rd_app_rdy),
    .app_rd_data        (app_rd_data),
    .app_rd_data_valid  (app_rd_data_valid),
    .rd_fifo_dat        (rd_fifo_dat),
    .rd_fifo_wr_en      (rd_fifo_wr_en),
    .rd_fifo_prog_full  (rd_fifo_prog_full),
    .ddr3_rd_done       (ddr3_rd_done),
    .ddr3_rd_hdr_err    (ddr3_rd_hdr_err),
    .ddr3_rd_unexp_data (ddr3_rd_unexp_data)
`ifdef DDR3_RD_HDR_CMP_EN
    ,
    .ddr3_rd_hdr_mismatch (ddr3_rd_hdr_mismatch)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    int           due;
  } word_t;

  word_t       exp_q[$];
  word_t       pend_q[$];
  logic [25:0] exp_addr [0:63];
  int          addr_wr = 0;
  int          addr_rd = 0;
  bit          chk_addr = 1'b1;
  int          errors = 0;
  int          checks = 0;
  int          ncyc = 0;
  int          lat = 3;
  int          acc_cnt = 0;
  int          pop_cnt = 0;
  int          outst = 0;
  int          spur_req = 0;
  int          spur_done = 0;

  function automatic logic [127:0] data_of(input logic [25:0] a);
    return {6'h15, a, 6'h2A, ~a, 6'h33, a ^ 26'h2AAAAAA, 6'h0C, a + 26'h1234567};
  endfunction

  function automatic logic [127:0] make_hdr(input logic [1:0] tag, input logic [22:0] start,
                                            input logic [23:0] burst);
    logic [127:0] h;
    h = {$urandom, $urandom, $urandom, $urandom};
    h[127:126] = tag;
    h[87:64]   = burst;
    h[57:35]   = start;
    return h;
  endfunction

  // Per-cycle memory model and scoreboard, run at the falling edge
  task automatic mon();
    word_t w;
    ncyc++;
    if (exp_q.size() != 0 && exp_q[0].due == ncyc) begin
      w = exp_q.pop_front();
      checks++;
      if (rd_fifo_wr_en !== 1'b1 || rd_fifo_dat !== w.d) begin
        errors++;
        $display("FAIL fwd_data: cycle %0d wr_en=%b dat=%h, required wr_en=1 dat=%h",
                 ncyc, rd_fifo_wr_en, rd_fifo_dat, w.d);
      end
    end else if (rd_fifo_wr_en !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL fwd_extra: cycle %0d wr_en=%b dat=%h, required wr_en=0", ncyc,
               rd_fifo_wr_en, rd_fifo_dat);
    end
    if (fill_header_rd_en === 1'b1) pop_cnt++;
    if (rd_app_en === 1'b1 && rd_app_rdy === 1'b1) begin
      acc_cnt++;
      outst++;
      w.d   = data_of(ddr3_rd_addr);
      w.due = ncyc + lat;
      pend_q.push_back(w);
      if (chk_addr) begin
        checks++;
        if (addr_rd == addr_wr) begin
          errors++;
          $display("FAIL cmd_extra: addr=%h issued, required no command", ddr3_rd_addr);
        end else begin
          if (ddr3_rd_addr !== exp_addr[addr_rd[5:0]]) begin
            errors++;
            $display("FAIL cmd_addr: addr=%h, required %h", ddr3_rd_addr, exp_addr[addr_rd[5:0]]);
          end
          addr_rd++;
        end
      end
    end
    if (!chk_addr) addr_rd = addr_wr;
    if (pend_q.size() != 0 && pend_q[0].due <= ncyc) begin
      w = pend_q.pop_front();
      app_rd_data_valid = 1'b1;
      app_rd_data = w.d;
      outst--;
      w.due = ncyc + 1;
      exp_q.push_back(w);
    end else if (spur_req != spur_done) begin
      spur_done++;
      app_rd_data_valid = 1'b1;
      app_rd_data = 128'hDEADBEEF_0BAD_F00D_5A5A_A5A5_1234_5678 ^ 128'(spur_done);
      w.d   = app_rd_data;
      w.due = ncyc + 1;
      exp_q.push_back(w);
    end else begin
      app_rd_data_valid = 1'b0;
      app_rd_data = '0;
    end
    if (rd_app_en === 1'b1 && rd_app_rdy === 1'b1) begin
      checks++;
      if (outst > MAXI) begin
        errors++;
        $display("FAIL inflight: outstanding=%0d, required <= %0d", outst, MAXI);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    mon();
  endtask

  task automatic cyc();
    tick();
    step();
  endtask

  task automatic start_fill(input logic [1:0] tag, input logic [22:0] start, input int burst,
                            input bit push_addr);
    if (push_addr) begin
      for (int i = 0; i < burst + 2; i++) begin
        exp_addr[addr_wr[5:0]] = {start + 23'(i), 3'b000};
        addr_wr++;
      end
    end
    tick();
    fill_header_dat   = make_hdr(tag, start, 24'(burst));
    fill_header_empty = 1'b0;
    step();
  endtask

  task automatic release_hdr();
    cyc();
    tick();
    fill_header_empty = 1'b1;
    step();
  endtask

  task automatic finish_fill(input string name, input int burst, input int p0, input int a0);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      cyc();
      if (ddr3_rd_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: ddr3_rd_done=0 after 400 cycles, required 1", name);
    end
    cyc();
    checks++;
    if (ddr3_rd_done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: ddr3_rd_done=%b, required 0", name, ddr3_rd_done);
    end
    for (int k = 0; k < 60 && (exp_q.size() != 0 || pend_q.size() != 0); k++) cyc();
    checks++;
    if (exp_q.size() != 0 || pend_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d words not forwarded, required 0", name,
               exp_q.size() + pend_q.size());
    end
    checks++;
    if (pop_cnt - p0 != 1) begin
      errors++;
      $display("FAIL %s pops: %0d, required 1", name, pop_cnt - p0);
    end
    checks++;
    if (acc_cnt - a0 != burst + 2) begin
      errors++;
      $display("FAIL %s cmds: %0d, required %0d", name, acc_cnt - a0, burst + 2);
    end
    checks++;
    if (addr_rd != addr_wr) begin
      errors++;
      $display("FAIL %s addr_count: %0d addresses not issued, required 0", name, addr_wr - addr_rd);
    end
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    checks++;
    if ({rd_app_en, fill_header_rd_en, rd_fifo_wr_en, ddr3_rd_done, ddr3_rd_hdr_err,
         ddr3_rd_unexp_data} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: %b, required 000000", {rd_app_en, fill_header_rd_en,
               rd_fifo_wr_en, ddr3_rd_done, ddr3_rd_hdr_err, ddr3_rd_unexp_data});
    end
    checks++;
    if (ddr3_rd_addr !== 26'h0 || rd_fifo_dat !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h dat=%h, required 0", ddr3_rd_addr, rd_fifo_dat);
    end
    tick();
    reset = 1'b0;
    rd_enabled = 1'b1;
    step();
    cyc();
    checks++;
    if (rd_app_en !== 1'b0 || fill_header_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_outputs: rd_app_en=%b pop=%b, required 0 0", rd_app_en, fill_header_rd_en);
    end
  endtask

  task automatic test_basic_fill();
    int p0, a0;
    p0 = pop_cnt;
    a0 = acc_cnt;
    lat = 3;
    start_fill(2'b01, 23'h000010, 3, 1'b1);
    cyc();
    checks++;
    if (fill_header_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL basic_pop_latency: fill_header_rd_en=%b, required 1", fill_header_rd_en);
    end
    tick();
    fill_header_empty = 1'b1;
    step();
    checks++;
    if (rd_app_en !== 1'b1 || ddr3_rd_addr !== 26'h80) begin
      errors++;
      $display("FAIL basic_cmd_latency: rd_app_en=%b addr=%h, required 1 0000080", rd_app_en,
               ddr3_rd_addr);
    end
    finish_fill("basic", 3, p0, a0);
  endtask

  task automatic test_hdr_err();
    int p0;
    bit bad;
    p0 = pop_cnt;
    bad = 1'b0;
    tick();
    fill_header_dat   = make_hdr(2'b10, 23'h000020, 24'd2);
    fill_header_empty = 1'b0;
    step();
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (rd_app_en !== 1'b0 || fill_header_rd_en !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hdr_err_quiet: command or pop seen, required none");
    end
    checks++;
    if (ddr3_rd_hdr_err !== 1'b1 || pop_cnt != p0) begin
      errors++;
      $display("FAIL hdr_err_flag: hdr_err=%b pops=%0d, required 1 0", ddr3_rd_hdr_err, pop_cnt - p0);
    end
    tick();
    reset = 1'b1;
    fill_header_empty = 1'b1;
    step();
    cyc();
    tick();
    reset = 1'b0;
    step();
    checks++;
    if (ddr3_rd_hdr_err !== 1'b0) begin
      errors++;
      $display("FAIL hdr_err_clear: hdr_err=%b, required 0", ddr3_rd_hdr_err);
    end
  endtask

  task automatic test_wrap();
    int p0, a0;
    p0 = pop_cnt;
    a0 = acc_cnt;
    lat = 2;
    start_fill(2'b01, 23'h7FFFFE, 1, 1'b1);
    release_hdr();
    finish_fill("wrap", 1, p0, a0);
  endtask

  task automatic test_stall();
    int p0, a0;
    logic [25:0] hold;
    bit bad;
    p0 = pop_cnt;
    a0 = acc_cnt;
    lat = 20;
    bad = 1'b0;
    rd_app_rdy = 1'b0;
    start_fill(2'b01, 23'h000100, 4, 1'b1);
    release_hdr();
    hold = ddr3_rd_addr;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (rd_app_en !== 1'b1 || ddr3_rd_addr !== hold) bad = 1'b1;
    end
    checks++;
    if (bad || hold !== 26'h800) begin
      errors++;
      $display("FAIL stall_hold: addr=%h start=%h en=%b, required stable 0000800 en=1",
               ddr3_rd_addr, hold, rd_app_en);
    end
    tick();
    rd_app_rdy = 1'b1;
    step();
    finish_fill("stall", 4, p0, a0);
  endtask

  task automatic test_prog_full();
    int p0, a0;
    bit bad;
    p0 = pop_cnt;
    a0 = acc_cnt;
    lat = 4;
    bad = 1'b0;
    start_fill(2'b01, 23'h002000, 6, 1'b1);
    release_hdr();
    for (int k = 0; k < 30 && acc_cnt - a0 < 2; k++) cyc();
    checks++;
    if (acc_cnt - a0 < 2) begin
      errors++;
      $display("FAIL pf_start: %0d commands, required >= 2", acc_cnt - a0);
    end
    tick();
    rd_fifo_prog_full = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (rd_app_en !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL pf_block: rd_app_en=1 while prog_full, required 0");
    end
    tick();
    rd_fifo_prog_full = 1'b0;
    step();
    checks++;
    if (rd_app_en !== 1'b1) begin
      errors++;
      $display("FAIL pf_resume: rd_app_en=%b, required 1", rd_app_en);
    end
    finish_fill("prog_full", 6, p0, a0);
  endtask

  task automatic test_unexp();
    tick();
    spur_req++;
    step();
    cyc();
    cyc();
    checks++;
    if (ddr3_rd_unexp_data !== 1'b1 || rd_app_en !== 1'b0) begin
      errors++;
      $display("FAIL unexp_flag: unexp=%b rd_app_en=%b, required 1 0", ddr3_rd_unexp_data, rd_app_en);
    end
  endtask

  task automatic test_reset_midfill();
    int a0;
    a0 = acc_cnt;
    chk_addr = 1'b0;
    lat = 20;
    start_fill(2'b01, 23'h003000, 6, 1'b0);
    release_hdr();
    for (int k = 0; k < 30 && acc_cnt - a0 < 2; k++) cyc();
    tick();
    reset = 1'b1;
    fill_header_empty = 1'b1;
    step();
    tick();
    reset = 1'b0;
    step();
    checks++;
    if (rd_app_en !== 1'b0 || ddr3_rd_unexp_data !== 1'b0 || ddr3_rd_addr !== 26'h0) begin
      errors++;
      $display("FAIL midreset_state: en=%b unexp=%b addr=%h, required 0 0 0", rd_app_en,
               ddr3_rd_unexp_data, ddr3_rd_addr);
    end
    for (int k = 0; k < 40 && pend_q.size() != 0; k++) cyc();
    cyc();
    cyc();
    checks++;
    if (ddr3_rd_unexp_data !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_late: unexp=%b pending=%0d, required 1 0", ddr3_rd_unexp_data,
               exp_q.size());
    end
    chk_addr = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_hdr_err();
    test_wrap();
    test_stall();
    test_prog_full();
    test_unexp();
    test_reset_midfill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
